// File: rtl/des_task_out_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : des_task_out_queue_if
// Purpose  : Core-side task_out stream, done/hold pair and task-unit stream
// Revision : 1.0
// ============================================================================
interface des_task_out_queue_if #(
    parameter int TQ_WIDTH  = 64,
    parameter int LOG_DEPTH = 3
);
    logic [TQ_WIDTH-1:0]  task_out_V_TDATA;
    logic                 task_out_V_TVALID;
    logic                 task_out_V_TREADY;
    logic                 ap_done;
    logic                 core_hold;
    logic [TQ_WIDTH-1:0]  m_task_TDATA;
    logic                 m_task_is_finish;
    logic                 m_task_TVALID;
    logic                 m_task_TREADY;
    logic [LOG_DEPTH:0]   occupancy;

    // Queue side
    modport slave (
        input  task_out_V_TDATA, task_out_V_TVALID, ap_done, m_task_TREADY,
        output task_out_V_TREADY, core_hold, m_task_TDATA, m_task_is_finish,
               m_task_TVALID, occupancy
    );

    // Core / task-unit side
    modport master (
        output task_out_V_TDATA, task_out_V_TVALID, ap_done, m_task_TREADY,
        input  task_out_V_TREADY, core_hold, m_task_TDATA, m_task_is_finish,
               m_task_TVALID, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/des_task_out_queue.sv
`default_nettype none
// ============================================================================
// Module   : des_task_out_queue
// Purpose  : FIFO of child tasks with in-order per-parent FINISH markers.
//            Optional counters enabled by DES_OUT_QUEUE_STATS_EN.
// Revision : 1.0
// ============================================================================
module des_task_out_queue #(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = $clog2(DEPTH),
    parameter int CNT_W     = 16,
    parameter int TQ_WIDTH  = 64
) (
    input  wire logic             ap_clk,
    input  wire logic             ap_rst,
    des_task_out_queue_if.slave   bus
`ifdef DES_OUT_QUEUE_STATS_EN
    ,
    output logic [31:0]           stat_children,
    output logic [31:0]           stat_finishes,
    output logic [31:0]           stat_full_cycles
`endif
);

    localparam logic [LOG_DEPTH:0] c_DEPTH = (LOG_DEPTH+1)'(DEPTH);

    logic [TQ_WIDTH:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0]  r_rd_ptr;
    logic [LOG_DEPTH-1:0]  r_wr_ptr;
    logic [LOG_DEPTH:0]    r_occ;
    logic [CNT_W-1:0]      r_child_cnt;
    logic [CNT_W-1:0]      r_fin_cnt;
    logic                  r_fin_pending;

    logic                  w_full;
    logic                  w_not_empty;
    logic                  w_child_push;
    logic                  w_fin_push;
    logic                  w_done_direct;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_child_inc;
    logic [TQ_WIDTH:0]     w_push_entry;
    logic [TQ_WIDTH:0]     w_head;

    assign w_full        = (r_occ == c_DEPTH);
    assign w_not_empty   = (r_occ != '0);
    assign w_fin_push    = r_fin_pending & ~w_full;
    assign w_child_push  = bus.task_out_V_TVALID & ~w_full & ~r_fin_pending;
    assign w_done_direct = bus.ap_done & ~w_full & ~w_child_push & ~r_fin_pending;
    assign w_push        = w_fin_push | w_child_push | w_done_direct;
    assign w_pop         = w_not_empty & bus.m_task_TREADY;

    always_comb begin
        w_child_inc = r_child_cnt;
        if (w_child_push && (r_child_cnt != '1))
            w_child_inc = r_child_cnt + 1'b1;

        w_push_entry = '0;
        if (w_fin_push)
            w_push_entry = {1'b1, {(TQ_WIDTH-CNT_W){1'b0}}, r_fin_cnt};
        else if (w_child_push)
            w_push_entry = {1'b0, bus.task_out_V_TDATA};
        else if (w_done_direct)
            w_push_entry = {1'b1, {(TQ_WIDTH-CNT_W){1'b0}}, r_child_cnt};
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge ap_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_entry;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_occ         <= '0;
            r_child_cnt   <= '0;
            r_fin_cnt     <= '0;
            r_fin_pending <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_occ <= r_occ + 1'b1;
            else if (!w_push && w_pop)
                r_occ <= r_occ - 1'b1;

            if (w_fin_push)
                r_fin_pending <= 1'b0;

            // A deferred finish must include a child accepted in the same cycle.
            if (bus.ap_done && !w_done_direct) begin
                r_fin_pending <= 1'b1;
                r_fin_cnt     <= w_child_inc;
                r_child_cnt   <= '0;
            end else if (bus.ap_done) begin
                r_child_cnt   <= '0;
            end else begin
                r_child_cnt   <= w_child_inc;
            end
        end
    end

    assign w_head                = r_mem[r_rd_ptr];
    assign bus.m_task_TVALID     = w_not_empty;
    assign bus.m_task_TDATA      = w_not_empty ? w_head[TQ_WIDTH-1:0] : '0;
    assign bus.m_task_is_finish  = w_not_empty & w_head[TQ_WIDTH];
    assign bus.task_out_V_TREADY = ~ap_rst & ~w_full & ~r_fin_pending;
    assign bus.core_hold         = r_fin_pending | w_full;
    assign bus.occupancy         = r_occ;

`ifdef DEBUG
    a_no_done_while_pending : assert property (
        @(posedge ap_clk) disable iff (ap_rst) !(bus.ap_done && r_fin_pending));
`endif

`ifdef DES_OUT_QUEUE_STATS_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stat_children    <= '0;
            stat_finishes    <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (w_child_push && (stat_children != '1))
                stat_children <= stat_children + 1'b1;
            if ((w_fin_push || w_done_direct) && (stat_finishes != '1))
                stat_finishes <= stat_finishes + 1'b1;
            if (w_full && (stat_full_cycles != '1))
                stat_full_cycles <= stat_full_cycles + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
